multicycle_control_fsm: RTL

- Main control unit of the 16-bit multicycle CPU.
- Sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback steps.
- Drives ALUOp into the ALUControl block; ALUControl resolves the final ALUCtrl from Funct/OPCode.
- Handles the unified-memory ready handshake and counts retired instructions.

---
 rtl/cpu_ctrl_pkg.sv | 73 +++++++
 rtl/retire_counter.sv | 39 +++
 rtl/multicycle_control_fsm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the 16-bit multicycle CPU control path
//
// Purpose: opcode map, ALUOp / ALUSrcB / PCSource encodings, FSM state codes and
// the packed control-word type used by multicycle_control_fsm. ALUControl imports
// the ALUOP_* constants from here so both ends of the ALUOp bus agree.
// Ports: none (package).

package cpu_ctrl_pkg;

    // Opcode map, IR[15:13]
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ANDI  = 3'b001;
    localparam logic [2:0] OP_ORI   = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_J     = 3'b111;

    // Funct value that turns OP_J into a halt
    localparam logic [3:0] FUNCT_HALT = 4'b1111;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    // PCSource encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM state encoding; codes 12..15 are unused and recover to ST_FETCH
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_WB_ALU   = 4'd4;
    localparam logic [3:0] ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] ST_MEM_RD   = 4'd6;
    localparam logic [3:0] ST_WB_MEM   = 4'd7;
    localparam logic [3:0] ST_MEM_WR   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JUMP     = 4'd10;
    localparam logic [3:0] ST_HALT     = 4'd11;

    // Full control word; all-zero is the idle / reset value
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - wrapping retired-instruction counter
//
// Purpose: counts Retire pulses, wraps from 2^CNT_W-1 to 0.
// Ports:
//   clk    in           clock, rising edge
//   rst_n  in           asynchronous active-low clear
//   en     in           increment enable (one Retire pulse)
//   count  out [CNT_W]  current count

module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - main control FSM of the 16-bit multicycle CPU
//
// Purpose: sequences PC/IR/register file/ALU/unified memory through
// fetch/decode/execute/memory/writeback, handles the memory ready handshake
// and counts retired instructions.
// Ports:
//   Clock, Reset(async, active-low)        clocking
//   OPCode[3], Funct[4], Zero, MemReady    status inputs
//   MemReq, MemWE, IorD                    memory control
//   IRWrite, PCWrite, PCWriteCond, PCSource[2]
//   RegWrite, RegDst, MemToReg             register file control
//   ALUSrcA, ALUSrcB[2], ALUOp[2]          ALU control
//   Halted, Retire, RetireCount[CNT_W]     status outputs

module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter bit FETCH_ONLY_HALT = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       OPCode,
    input  logic [3:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWE,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             Halted,
    output logic             Retire,
    output logic [CNT_W-1:0] RetireCount
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;

    // Zero is consumed by the datapath through PCWriteCond, not by the FSM
    logic unused_zero;
    assign unused_zero = Zero;

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                // IR load and PC+1 commit only on the cycle memory delivers
                if (MemReady) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_ALU;
                    state_d        = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
                case (OPCode)
                    OP_RTYPE:                 state_d = ST_EXEC_R;
                    OP_ANDI, OP_ORI, OP_ADDI: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:             state_d = ST_MEM_ADDR;
                    OP_BEQ:                   state_d = ST_BRANCH;
                    OP_J: begin
                        if (FETCH_ONLY_HALT && (Funct == FUNCT_HALT)) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_JUMP;
                        end
                    end
                    default:                  state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                // Logical immediates are zero-extended, ADDI is sign-extended
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = (OPCode == OP_ADDI) ? SRCB_SEXT : SRCB_ZEXT;
                ctrl.alu_op    = ALUOP_IMM;
                state_d        = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = (OPCode == OP_RTYPE);
                ctrl.retire    = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (OPCode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (MemReady) begin
                    state_d = ST_WB_MEM;
                end
            end
            ST_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                // A store retires on the cycle the write is accepted
                if (MemReady) begin
                    ctrl.retire = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
                state_d            = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
                state_d        = ST_FETCH;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
                state_d     = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset masks the whole control word so an in-flight memory request
    // drops asynchronously rather than waiting for the next clock edge.
    assign ctrl_out = Reset ? ctrl : '0;

    assign MemReq      = ctrl_out.mem_req;
    assign MemWE       = ctrl_out.mem_we;
    assign IorD        = ctrl_out.iord;
    assign IRWrite     = ctrl_out.ir_write;
    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign PCSource    = ctrl_out.pc_source;
    assign RegWrite    = ctrl_out.reg_write;
    assign RegDst      = ctrl_out.reg_dst;
    assign MemToReg    = ctrl_out.mem_to_reg;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ALUOp       = ctrl_out.alu_op;
    assign Halted      = ctrl_out.halted;
    assign Retire      = ctrl_out.retire;

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (Clock),
        .rst_n (Reset),
        .en    (ctrl_out.retire),
        .count (RetireCount)
    );

endmodule
